alu_seq_core: RTL

Registered, parametrised ALU execution stage for the ARM processor datapath. It computes the opcode-selected result from two N-bit operands and registers the result with NZCV flags. Results are returned over a START/READY/DONE handshake. All opcodes complete in one cycle except unsigned division, which runs as an N-cycle restoring iteration. It replaces the purely combinational ALU result selection, adds flag generation, and makes division multi-cycle.

---
 rtl/alu_seq_core.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_core.sv
// Registered ALU execution stage with NZCV flags and a START/READY/DONE handshake.
// Every opcode finishes in one cycle except unsigned DIV, which iterates one quotient bit per cycle.
module alu_seq_core #(
    parameter int N = 32
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         START,
    input  logic [3:0]   SELECTOR,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         READY,
    output logic         DONE,
    output logic [N-1:0] OUT,
    output logic [3:0]   FLAGS,
    output logic         DIV_BY_ZERO
);

    localparam int SW = $clog2(N);
    localparam int CW = SW + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_NOT   = 4'b0101;
    localparam logic [3:0] OP_LSL_A = 4'b0110;
    localparam logic [3:0] OP_ASR   = 4'b0111;
    localparam logic [3:0] OP_LSL   = 4'b1000;
    localparam logic [3:0] OP_LSR   = 4'b1001;
    localparam logic [3:0] OP_DIV   = 4'b1010;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_DIVIDE = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   out_q, out_d;
    logic [3:0]     flags_q, flags_d;
    logic           done_q, done_d;
    logic           dbz_q, dbz_d;
    logic [N-1:0]   divisor_q, divisor_d;
    logic [N:0]     rem_q, rem_d;
    logic [N-1:0]   quo_q, quo_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [SW-1:0]  sh_amt;
    logic [N:0]     add_ext;
    logic [N:0]     sub_ext;
    logic [N:0]     lsl_ext;
    logic [N:0]     lsr_ext;
    logic [N:0]     asr_ext;
    logic [N-1:0]   alu_out;
    logic           alu_c;
    logic           alu_v;
    logic [3:0]     alu_flags;

    logic [N:0]     rem_shift;
    logic           rem_ge;
    logic [N:0]     rem_step;
    logic [N-1:0]   quo_step;

    // Shifts carry one extra bit so the last bit shifted out lands in a fixed position.
    assign sh_amt  = B[SW-1:0];
    assign add_ext = {1'b0, A} + {1'b0, B};
    assign sub_ext = {1'b0, A} - {1'b0, B};
    assign lsl_ext = {1'b0, A} << sh_amt;
    assign lsr_ext = {A, 1'b0} >> sh_amt;
    assign asr_ext = $unsigned($signed({A, 1'b0}) >>> sh_amt);

    always_comb begin
        alu_out = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (SELECTOR)
            OP_ADD: begin
                alu_out = add_ext[N-1:0];
                alu_c   = add_ext[N];
                alu_v   = (A[N-1] == B[N-1]) && (add_ext[N-1] != A[N-1]);
            end
            OP_SUB: begin
                alu_out = sub_ext[N-1:0];
                alu_c   = ~sub_ext[N];
                alu_v   = (A[N-1] != B[N-1]) && (sub_ext[N-1] != A[N-1]);
            end
            OP_AND: alu_out = A & B;
            OP_OR:  alu_out = A | B;
            OP_XOR: alu_out = A ^ B;
            OP_NOT: alu_out = ~A;
            OP_LSL_A, OP_LSL: begin
                alu_out = lsl_ext[N-1:0];
                alu_c   = lsl_ext[N];
            end
            OP_ASR: begin
                alu_out = asr_ext[N:1];
                alu_c   = asr_ext[0];
            end
            OP_LSR: begin
                alu_out = lsr_ext[N:1];
                alu_c   = lsr_ext[0];
            end
            OP_DIV: alu_out = (B == '0) ? '1 : '0;
            default: alu_out = '0;
        endcase
    end

    assign alu_flags = {alu_out[N-1], (alu_out == '0), alu_c, alu_v};

    // Restoring step: the quotient register doubles as the dividend shifter.
    assign rem_shift = {rem_q[N-1:0], quo_q[N-1]};
    assign rem_ge    = rem_q[N] | (rem_shift >= {1'b0, divisor_q});
    assign rem_step  = rem_ge ? (rem_shift - {1'b0, divisor_q}) : rem_shift;
    assign quo_step  = {quo_q[N-2:0], rem_ge};

    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        flags_d   = flags_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    if ((SELECTOR == OP_DIV) && (B != '0)) begin
                        state_d   = S_DIVIDE;
                        divisor_d = B;
                        quo_d     = A;
                        rem_d     = '0;
                        cnt_d     = '0;
                    end else begin
                        out_d   = alu_out;
                        flags_d = alu_flags;
                        dbz_d   = (SELECTOR == OP_DIV);
                        done_d  = 1'b1;
                    end
                end
            end
            S_DIVIDE: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    out_d   = quo_step;
                    flags_d = {quo_step[N-1], (quo_step == '0), 2'b00};
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= S_IDLE;
            out_q     <= '0;
            flags_q   <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            flags_q   <= flags_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
        end
    end

    assign READY       = (state_q == S_IDLE);
    assign DONE        = done_q;
    assign OUT         = out_q;
    assign FLAGS       = flags_q;
    assign DIV_BY_ZERO = dbz_q;

endmodule
